// File: rtl/local_mem_rw_engine.sv
// Write/read-back checker for one local memory bank over single-beat AXI-MM.
// Writes a seeded line pattern, reads it back, and reports mismatch/error status.
module local_mem_rw_engine #(
  parameter int unsigned ADDR_WIDTH         = 33,
  parameter int unsigned DATA_WIDTH         = 512,
  parameter int unsigned CNT_WIDTH          = 16,
  parameter int unsigned MAX_RD_OUTSTANDING = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [CNT_WIDTH-1:0]      num_lines,
  input  logic [31:0]               seed,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [CNT_WIDTH-1:0]      err_count,
  output logic [ADDR_WIDTH-1:0]     first_err_addr,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic                      wvalid,
  input  logic                      wready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wlast,
  input  logic                      bvalid,
  output logic                      bready,
  input  logic [1:0]                bresp,
  output logic                      arvalid,
  input  logic                      arready,
  output logic [ADDR_WIDTH-1:0]     araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  input  logic                      rvalid,
  output logic                      rready,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [1:0]                rresp
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned WORDS = DATA_WIDTH / 32;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned OUT_W = $clog2(MAX_RD_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [OUT_W-1:0]      OUT_MAX  = OUT_W'(MAX_RD_OUTSTANDING);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_DRAIN, S_RD, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [CNT_WIDTH-1:0]  wr_idx_q, wr_idx_d;
  logic [31:0]           wr_word_q, wr_word_d;
  logic [ADDR_WIDTH-1:0] awaddr_d;
  logic                  awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic [CNT_WIDTH-1:0]  b_cnt_q, b_cnt_d;
  logic [ADDR_WIDTH-1:0] b_addr_q, b_addr_d;
  logic [ADDR_WIDTH-1:0] araddr_d;
  logic [CNT_WIDTH-1:0]  issued_q, issued_d;
  logic [OUT_W-1:0]      outst_q, outst_d;
  logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic [31:0]           rd_word_q, rd_word_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  busy_d, done_d, pass_d;
  logic [CNT_WIDTH-1:0]  err_d;
  logic [ADDR_WIDTH-1:0] first_err_d;

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, line_acc;
  logic                  b_err, r_err, ev;
  logic [ADDR_WIDTH-1:0] ev_addr, base_al;

  assign awlen  = 8'd0;
  assign arlen  = 8'd0;
  assign awsize = 3'(OFF_W);
  assign arsize = 3'(OFF_W);
  assign wstrb  = '1;
  assign wlast  = 1'b1;
  assign wdata  = {WORDS{wr_word_q}};

  assign aw_hs    = awvalid & awready;
  assign w_hs     = wvalid & wready;
  assign b_hs     = bvalid & bready;
  assign ar_hs    = arvalid & arready;
  assign r_hs     = rvalid & rready;
  // A line is finished once each channel has handshaken, now or earlier.
  assign line_acc = (!awvalid || awready) && (!wvalid || wready);
  assign base_al  = base_addr & ~OFF_MASK;

  assign b_err   = b_hs && (bresp != 2'b00);
  assign r_err   = r_hs && ((rresp != 2'b00) || (rdata != {WORDS{rd_word_q}}));
  assign ev      = b_err || r_err;
  assign ev_addr = b_err ? b_addr_q : rd_addr_q;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    wr_idx_d    = wr_idx_q;
    wr_word_d   = wr_word_q;
    awaddr_d    = awaddr;
    awvalid_d   = awvalid;
    wvalid_d    = wvalid;
    b_cnt_d     = b_cnt_q;
    b_addr_d    = b_addr_q;
    araddr_d    = araddr;
    issued_d    = issued_q;
    outst_d     = outst_q;
    rd_cnt_d    = rd_cnt_q;
    rd_word_d   = rd_word_q;
    rd_addr_d   = rd_addr_q;
    pass_d      = pass;
    err_d       = err_count;
    first_err_d = first_err_addr;

    case (state_q)
      S_IDLE: begin
        if (start && !done) begin
          num_d       = num_lines;
          wr_idx_d    = '0;
          wr_word_d   = seed;
          rd_word_d   = seed;
          awaddr_d    = base_al;
          b_addr_d    = base_al;
          araddr_d    = base_al;
          rd_addr_d   = base_al;
          b_cnt_d     = '0;
          issued_d    = '0;
          outst_d     = '0;
          rd_cnt_d    = '0;
          pass_d      = 1'b0;
          err_d       = '0;
          first_err_d = '0;
          if (num_lines == '0) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end
      S_WR: begin
        awvalid_d = awvalid & ~awready;
        wvalid_d  = wvalid & ~wready;
        if (line_acc) begin
          wr_idx_d  = wr_idx_q + CNT_WIDTH'(1);
          awaddr_d  = awaddr + STRIDE;
          wr_word_d = wr_word_q + 32'd1;
          if (wr_idx_d == num_q) begin
            state_d = S_WR_DRAIN;
          end else begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end
      S_WR_DRAIN: begin
        if (b_cnt_q == num_q) state_d = S_RD;
      end
      S_RD: begin
        if (r_hs && (rd_cnt_q + CNT_WIDTH'(1) == num_q)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        pass_d  = (err_count == '0);
      end
      default: state_d = S_IDLE;
    endcase

    if (b_hs) begin
      b_cnt_d  = b_cnt_q + CNT_WIDTH'(1);
      b_addr_d = b_addr_q + STRIDE;
    end
    if (ar_hs) begin
      issued_d = issued_q + CNT_WIDTH'(1);
      araddr_d = araddr + STRIDE;
    end
    if (r_hs) begin
      rd_cnt_d  = rd_cnt_q + CNT_WIDTH'(1);
      rd_word_d = rd_word_q + 32'd1;
      rd_addr_d = rd_addr_q + STRIDE;
    end
    if (ar_hs && !r_hs)      outst_d = outst_q + OUT_W'(1);
    else if (!ar_hs && r_hs) outst_d = outst_q - OUT_W'(1);

    // At most one error event per cycle: B and R never overlap in time.
    if (ev) begin
      if (err_count != '1)     err_d       = err_count + CNT_WIDTH'(1);
      if (err_count == '0)     first_err_d = ev_addr;
    end

    bready_d  = (state_d == S_WR) || (state_d == S_WR_DRAIN);
    rready_d  = (state_d == S_RD);
    arvalid_d = (state_d == S_RD) && (issued_d < num_q) && (outst_d < OUT_MAX);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_q == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      num_q          <= '0;
      wr_idx_q       <= '0;
      wr_word_q      <= '0;
      awaddr         <= '0;
      awvalid        <= 1'b0;
      wvalid         <= 1'b0;
      bready         <= 1'b0;
      b_cnt_q        <= '0;
      b_addr_q       <= '0;
      arvalid        <= 1'b0;
      araddr         <= '0;
      issued_q       <= '0;
      outst_q        <= '0;
      rready         <= 1'b0;
      rd_cnt_q       <= '0;
      rd_word_q      <= '0;
      rd_addr_q      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state_q        <= state_d;
      num_q          <= num_d;
      wr_idx_q       <= wr_idx_d;
      wr_word_q      <= wr_word_d;
      awaddr         <= awaddr_d;
      awvalid        <= awvalid_d;
      wvalid         <= wvalid_d;
      bready         <= bready_d;
      b_cnt_q        <= b_cnt_d;
      b_addr_q       <= b_addr_d;
      arvalid        <= arvalid_d;
      araddr         <= araddr_d;
      issued_q       <= issued_d;
      outst_q        <= outst_d;
      rready         <= rready_d;
      rd_cnt_q       <= rd_cnt_d;
      rd_word_q      <= rd_word_d;
      rd_addr_q      <= rd_addr_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      err_count      <= err_d;
      first_err_addr <= first_err_d;
    end
  end

endmodule

// File: tb/tb_local_mem_rw_engine.sv
// Bench for local_mem_rw_engine: randomized AXI slave memory plus a line-level
// reference model of addresses, data, and expected error status.
module tb_local_mem_rw_engine;

  localparam int unsigned AW = 33;
  localparam int unsigned DW = 512;
  localparam int unsigned CW = 16;
  localparam int unsigned MAX_OUT = 16;
  localparam int unsigned BYTES = DW / 8;

  logic clk = 1'b0;
  logic rst, start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_lines;
  logic [31:0] seed;
  logic busy, done, pass;
  logic [CW-1:0] err_count;
  logic [AW-1:0] first_err_addr;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0] bresp, rresp;

  local_mem_rw_engine dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_lines(num_lines), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [1:0] resp; } b_ent_t;
  typedef struct { int due; logic [DW-1:0] data; logic [1:0] resp; } r_ent_t;

  int n_checks = 0;
  int n_fail = 0;

  // Run configuration and observed-traffic bookkeeping
  logic [AW-1:0] cfg_base = '0;
  logic [31:0]   cfg_seed = '0;
  int cfg_num = 0, cfg_rdy = 100, cfg_lat = 1;
  int cfg_berr = -1, cfg_rerr = -1, cfg_corrupt = -1;
  bit run_active = 1'b0;
  int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0, pair_n = 0, done_cnt = 0, cyc = 0;
  logic [AW-1:0] aw_log[$];
  logic [31:0]   w_log[$];
  logic [AW-1:0] paw[$];
  logic [DW-1:0] pw[$];
  b_ent_t bq[$];
  r_ent_t rq[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return cfg_base + AW'(i) * AW'(BYTES);
  endfunction

  function automatic logic [DW-1:0] line_data(input int i);
    logic [31:0] w;
    w = cfg_seed + 32'(i);
    return {(DW/32){w}};
  endfunction

  function automatic int exp_errs();
    int e = 0;
    for (int i = 0; i < cfg_num; i++) begin
      if (i == cfg_berr) e++;
      if (i == cfg_corrupt || i == cfg_rerr) e++;
    end
    return e;
  endfunction

  // All B responses precede all R beats, so a B error is always the earliest event.
  function automatic logic [AW-1:0] exp_first();
    int r = -1;
    if (cfg_berr >= 0 && cfg_berr < cfg_num) return addr_of(cfg_berr);
    if (cfg_corrupt >= 0 && cfg_corrupt < cfg_num) r = cfg_corrupt;
    if (cfg_rerr >= 0 && cfg_rerr < cfg_num && (r < 0 || cfg_rerr < r)) r = cfg_rerr;
    return (r >= 0) ? addr_of(r) : '0;
  endfunction

  // Slave memory and per-cycle compare process
  initial begin : mem_slave
    b_ent_t be;
    r_ent_t re;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        paw.delete(); pw.delete(); bq.delete(); rq.delete();
      end else begin
        if (awvalid) check("aw_fixed", DW'({awlen, awsize}), DW'({8'd0, 3'd6}));
        if (wvalid) check("w_fixed", DW'({wstrb, wlast}), DW'({64'hFFFF_FFFF_FFFF_FFFF, 1'b1}));
        if (arvalid) begin
          check("ar_fixed", DW'({arlen, arsize}), DW'({8'd0, 3'd6}));
          check("ar_after_all_b", DW'(b_n), DW'(cfg_num));
        end
        if (run_active && cfg_num == 0)
          check("no_traffic", DW'({awvalid, wvalid, arvalid}), DW'(0));
        if (awvalid && awready) begin
          check("awaddr", DW'(awaddr), DW'(addr_of(aw_n)));
          aw_log.push_back(awaddr);
          paw.push_back(awaddr);
          aw_n++;
        end
        if (wvalid && wready) begin
          check("wdata", wdata, line_data(w_n));
          w_log.push_back(wdata[31:0]);
          pw.push_back(wdata);
          w_n++;
        end
        if (paw.size() > 0 && pw.size() > 0) begin
          a = paw.pop_front();
          d = pw.pop_front();
          mem[a] = d;
          be.due = cyc + int'($urandom_range(1, cfg_lat));
          be.resp = (pair_n == cfg_berr) ? 2'b10 : 2'b00;
          bq.push_back(be);
          pair_n++;
        end
        if (bvalid && bready) begin
          bq.delete(0);
          b_n++;
        end
        if (arvalid && arready) begin
          check("araddr", DW'(araddr), DW'(addr_of(ar_n)));
          re.data = mem.exists(araddr) ? mem[araddr] : '0;
          if (ar_n == cfg_corrupt) re.data[100] = ~re.data[100];
          re.resp = (ar_n == cfg_rerr) ? 2'b10 : 2'b00;
          re.due = cyc + int'($urandom_range(1, cfg_lat));
          rq.push_back(re);
          ar_n++;
        end
        if (rvalid && rready) begin
          rq.delete(0);
          r_n++;
        end
        if (rready) check("rd_outstanding_le_max", (ar_n - r_n <= int'(MAX_OUT)) ? DW'(1) : DW'(0), DW'(1));
        if (done) done_cnt++;
      end
      @(posedge clk);
      #1;
      awready = (int'($urandom_range(0, 99)) < cfg_rdy);
      wready  = (int'($urandom_range(0, 99)) < cfg_rdy);
      arready = (int'($urandom_range(0, 99)) < cfg_rdy);
      if (bq.size() > 0 && bq[0].due <= cyc) begin
        bvalid = 1'b1; bresp = bq[0].resp;
      end else begin
        bvalid = 1'b0; bresp = 2'b00;
      end
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        rvalid = 1'b1; rdata = rq[0].data; rresp = rq[0].resp;
      end else begin
        rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      end
    end
  end

  task automatic start_run(input logic [AW-1:0] base, input int num, input logic [31:0] sd,
                           input int rdy, input int lat, input int berr, input int rerr,
                           input int corrupt);
    cfg_base = base & ~AW'(BYTES - 1);
    cfg_num = num; cfg_seed = sd; cfg_rdy = rdy; cfg_lat = lat;
    cfg_berr = berr; cfg_rerr = rerr; cfg_corrupt = corrupt;
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; pair_n = 0; done_cnt = 0;
    aw_log.delete(); w_log.delete();
    run_active = 1'b1;
    base_addr = base; num_lines = CW'(num); seed = sd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic finish_run(input bit poke);
    int waited = 1;
    while (!done && waited < 20000) begin
      if (poke && waited == 10) begin
        start = 1'b1; base_addr = 33'h0; num_lines = 16'd5; seed = 32'h0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    start = 1'b0;
    check("done_seen", DW'(done), DW'(1));
    if (cfg_num == 0) check("zero_done_latency", DW'(waited), DW'(2));
    check("busy_at_done", DW'(busy), DW'(0));
    check("pass", DW'(pass), (exp_errs() == 0) ? DW'(1) : DW'(0));
    check("err_count", DW'(err_count), DW'(exp_errs()));
    check("first_err_addr", DW'(first_err_addr), DW'(exp_first()));
    check("aw_beats", DW'(aw_n), DW'(cfg_num));
    check("w_beats", DW'(w_n), DW'(cfg_num));
    check("b_beats", DW'(b_n), DW'(cfg_num));
    check("ar_beats", DW'(ar_n), DW'(cfg_num));
    check("r_beats", DW'(r_n), DW'(cfg_num));
    // A start coincident with done must not launch a new test.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_on_done_ignored", DW'(busy), DW'(0));
    repeat (3) @(posedge clk);
    #1;
    check("done_single_pulse", DW'(done_cnt), DW'(1));
    check("status_held", DW'({pass, err_count}), DW'({(exp_errs() == 0), CW'(exp_errs())}));
    run_active = 1'b0;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [AW-1:0] lit_addr [4];
    logic [31:0]   lit_word [4];
    int waited;
    lit_addr = '{33'h1000, 33'h1040, 33'h1080, 33'h10C0};
    lit_word = '{32'hA5A50000, 32'hA5A50001, 32'hA5A50002, 32'hA5A50003};
    rst = 1'b1; start = 1'b0; base_addr = '0; num_lines = '0; seed = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_status", DW'({busy, done, pass, err_count, first_err_addr}), DW'(0));
    check("reset_valids", DW'({awvalid, wvalid, arvalid, bready, rready}), DW'(0));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Always-ready memory, literal address and data sequence
    start_run(33'h1000, 4, 32'hA5A50000, 100, 1, -1, -1, -1);
    finish_run(1'b0);
    check("t1_aw_count", DW'(aw_log.size()), DW'(4));
    for (int i = 0; i < 4 && i < aw_log.size(); i++) check("t1_awaddr_lit", DW'(aw_log[i]), DW'(lit_addr[i]));
    for (int i = 0; i < 4 && i < w_log.size(); i++) check("t1_wword_lit", DW'(w_log[i]), DW'(lit_word[i]));
    check("t1_pass_lit", DW'({pass, err_count}), DW'({1'b1, 16'd0}));

    // Line 2 corrupted on readback
    start_run(33'h1000, 4, 32'hA5A50000, 100, 1, -1, -1, 2);
    finish_run(1'b0);
    check("t2_lit", DW'({pass, err_count, first_err_addr}), DW'({1'b0, 16'd1, 33'h1080}));

    // Random backpressure and latency, unaligned base near the top of the address space
    start_run(33'h1_FFFF_F01F, 100, $urandom, 60, 8, -1, -1, -1);
    finish_run(1'b1);
    check("t3_pass_lit", DW'(pass), DW'(1));

    // Zero lines: no traffic, done two cycles after start
    start_run(33'h2000, 0, 32'h1, 100, 1, -1, -1, -1);
    finish_run(1'b0);

    // Write error on first line and read error on last line
    start_run(33'h3000, 3, 32'hDEAD0000, 100, 2, 0, 2, -1);
    finish_run(1'b0);
    check("t5_lit", DW'({err_count, first_err_addr}), DW'({16'd2, 33'h3000}));

    // Several randomized runs with mixed faults
    for (int k = 0; k < 4; k++) begin
      start_run({$urandom, 1'b0}, int'($urandom_range(1, 40)), $urandom,
                int'($urandom_range(30, 100)), int'($urandom_range(1, 6)),
                int'($urandom_range(0, 60)) - 20, int'($urandom_range(0, 60)) - 20,
                int'($urandom_range(0, 60)) - 20);
      finish_run(1'b0);
    end

    // Reset in the middle of the read phase
    start_run(33'h4000, 20, 32'h12345678, 100, 3, -1, -1, -1);
    waited = 0;
    while (!(rready && ar_n >= 3) && waited < 2000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("t6_reached_rd", DW'(rready), DW'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_arvalid", DW'(arvalid), DW'(0));
    check("t6_rst_busy", DW'(busy), DW'(0));
    rst = 1'b0;
    run_active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start_run(33'h5000, 2, 32'h0BAD_F00D, 100, 2, -1, -1, -1);
    finish_run(1'b0);
    check("t6_pass_lit", DW'(pass), DW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/local_mem_rw_engine.md
Name: local_mem_rw_engine

Overview:
- CSR-triggered write/read-back checker for one local memory bank, instantiated inside afu_top and driving the AFU-clock AXI-MM local memory interface that the platform shim delivers.
- On start it writes a seeded pattern to a contiguous line range, reads the range back, compares, and reports pass/fail status to the CSR block.
- All ports are flattened AXI-MM signals. Every transaction is single-beat, one full data-bus line.

Parameters:
- ADDR_WIDTH, 33, AXI byte-address width.
- DATA_WIDTH, 512, AXI data width; multiple of 32.
- CNT_WIDTH, 16, width of line count and error counter.
- MAX_RD_OUTSTANDING, 16, maximum in-flight reads; power of 2, at most 64.

Ports:
- clk  in  1  AFU clock; all logic is on this single clock.
- rst  in  1  Synchronous, active-high reset.
- start  in  1  One-cycle start pulse from CSR; ignored while busy=1.
- base_addr  in  ADDR_WIDTH  Byte address of line 0; low log2(DATA_WIDTH/8) bits treated as 0. Sampled on start.
- num_lines  in  CNT_WIDTH  Number of lines to test. Sampled on start.
- seed  in  32  Pattern seed. Sampled on start.
- busy  out  1  High from the cycle after an accepted start until done.
- done  out  1  One-cycle pulse at test completion.
- pass  out  1  Valid after done: err_count==0. Held until next start.
- err_count  out  CNT_WIDTH  Saturating count of mismatches plus error responses.
- first_err_addr  out  ADDR_WIDTH  Address of the first failing line; 0 if none.
- awvalid/awready/awaddr[ADDR_WIDTH]/awlen[8]/awsize[3]  out/in/out/out/out  Write address channel.
- wvalid/wready/wdata[DATA_WIDTH]/wstrb[DATA_WIDTH/8]/wlast  out/in/out/out/out  Write data channel.
- bvalid/bready/bresp[2]  in/out/in  Write response channel.
- arvalid/arready/araddr[ADDR_WIDTH]/arlen[8]/arsize[3]  out/in/out/out/out  Read address channel.
- rvalid/rready/rdata[DATA_WIDTH]/rresp[2]  in/out/in  Read data channel.

Behaviour:
- Fixed fields: awlen=arlen=0, awsize=arsize=log2(DATA_WIDTH/8), wstrb all ones, wlast=1. AXI IDs are 0 and responses are in order.
- Address of line i = base_addr + i*(DATA_WIDTH/8), computed modulo 2^ADDR_WIDTH (wraps silently).
- Data of line i = the 32-bit value (seed + i) mod 2^32, replicated DATA_WIDTH/32 times.
- Reset: FSM=IDLE, all valids 0, bready=rready=0, busy=done=0, pass=0, err_count=0, first_err_addr=0.
- FSM states: IDLE, WR, WR_DRAIN, RD, DONE.
- IDLE, start=1: capture the inputs, clear err_count and first_err_addr, set busy the next cycle. If num_lines==0, go to DONE (no traffic); otherwise go to WR.
- WR: awvalid and wvalid both assert for line i.
  - Each channel drops its valid independently once it handshakes.
  - Line i advances only after both channels have been accepted; the next line's valids may assert the following cycle.
  - After the last line is accepted on both channels, go to WR_DRAIN.
- bready=1 throughout WR and WR_DRAIN. The block counts B responses.
- WR_DRAIN: wait until B count == num_lines, then go to RD. Reads never start before all writes are acknowledged.
- RD: arvalid asserts while issued < num_lines and outstanding < MAX_RD_OUTSTANDING.
  - Outstanding increments on an AR handshake and decrements on an R handshake.
  - A simultaneous AR and R handshake leaves outstanding unchanged.
- rready=1 in RD. Each R beat is compared with the expected data for the next expected line index.
- When all num_lines R beats are received, go to DONE.
- Error events: bresp!=0, rresp!=0, or rdata mismatch. A mismatch with rresp!=0 on the same beat counts once.
  - err_count increments by 1 per event and saturates at all-ones.
  - first_err_addr is latched on the first event only. For B errors it records the address of the corresponding write, in order.
- DONE: done=1 for exactly one cycle, busy=0, pass=(err_count==0). Return to IDLE.
- Outputs pass, err_count and first_err_addr hold until the next accepted start.
- A start during busy has no effect. A start coincident with done is ignored.
- rst asserted mid-test: all state returns to reset values in the next cycle and valids drop immediately. The memory-side transaction loss is acceptable; the integrator pairs rst with the memory port reset.
- Latency with always-ready slaves: N lines take N cycles of writes, then about 1 cycle plus the B latency, then N reads plus the R latency, then 1 DONE cycle.

Test Plan:
- Ready/always-valid memory model, base_addr=0x1000, num_lines=4, seed=0xA5A50000: awaddr sequence 0x1000, 0x1040, 0x1080, 0x10C0; wdata words 0xA5A50000..0xA5A50003; done pulses once; pass=1; err_count=0.
- Same run with memory corrupting line 2 on readback: err_count=1, first_err_addr=0x1080, pass=0.
- Random backpressure on awready, wready and arready, and random B/R latency, with num_lines=100: no lost or duplicated beat; outstanding never exceeds 16; pass=1.
- num_lines=0: done pulses 2 cycles after start; no valid ever asserts; pass=1.
- bresp=2'b10 on the first write and rresp=2'b10 on the last read (data correct), num_lines=3: err_count=2; first_err_addr=base_addr.
- rst asserted mid-RD: the next cycle shows arvalid=0 and busy=0; a subsequent start with num_lines=2 completes with pass=1.
